// File: rtl/reg_file_16x16.sv
// reg_file_16x16
//   Sixteen-entry, 16-bit register file with a single synchronous write port.
//   All registers are driven as one flattened 256-bit bus for the downstream
//   16x16-to-16 read-select mux (mux In = regs_flat, mux S = read address).
//   Byte enables, per-register dirty tracking and a wrapping write counter.
//
// Parameters
//   ZERO_REG   1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
//   RESET_VAL  value loaded into every register on reset / clr_all
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset, overrides every other input
//   we         write enable
//   waddr      write address
//   wdata      write data
//   wbe        byte enables: [1] = bits 15:8, [0] = bits 7:0
//   clr_all    synchronous clear of all registers to RESET_VAL (dirty cleared too)
//   clr_dirty  synchronous clear of all dirty bits
//   regs_flat  register i on regs_flat[16*i+15 : 16*i]
//   dirty      dirty[i] = 1: register i written since last reset/clear
//   wr_count   committed writes, wraps 255 -> 0
module reg_file_16x16 #(
    parameter bit          ZERO_REG  = 1'b1,
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [3:0]   waddr,
    input  logic [15:0]  wdata,
    input  logic [1:0]   wbe,
    input  logic         clr_all,
    input  logic         clr_dirty,
    output logic [255:0] regs_flat,
    output logic [15:0]  dirty,
    output logic [7:0]   wr_count
);

    logic [15:0] regs_q [16];
    logic [15:0] regs_d [16];
    logic [15:0] dirty_q, dirty_d;
    logic [7:0]  wr_count_q, wr_count_d;
    logic        commit;

    // Value a register takes on reset or clear; register 0 is pinned when ZERO_REG.
    function automatic logic [15:0] init_val(input int unsigned idx);
        return (ZERO_REG && (idx == 0)) ? 16'h0000 : RESET_VAL;
    endfunction

    assign commit = we && (wbe != 2'b00) && !(ZERO_REG && (waddr == 4'd0));

    always_comb begin
        regs_d     = regs_q;
        dirty_d    = dirty_q;
        wr_count_d = wr_count_q;
        if (clr_all) begin
            // Clear wins over a same-cycle write; the write counter holds.
            for (int i = 0; i < 16; i++) begin
                regs_d[i] = init_val(i);
            end
            dirty_d = 16'h0000;
        end else begin
            if (clr_dirty) begin
                dirty_d = 16'h0000;
            end
            // Applied after clr_dirty so a committing write leaves only its own bit set.
            if (commit) begin
                if (wbe[0]) regs_d[waddr][7:0]  = wdata[7:0];
                if (wbe[1]) regs_d[waddr][15:8] = wdata[15:8];
                dirty_d[waddr] = 1'b1;
                wr_count_d     = wr_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= init_val(i);
            end
            dirty_q    <= 16'h0000;
            wr_count_q <= 8'h00;
        end else begin
            regs_q     <= regs_d;
            dirty_q    <= dirty_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Straight register outputs: no combinational path from the write port.
    for (genvar g = 0; g < 16; g++) begin : g_flat
        assign regs_flat[16*g +: 16] = regs_q[g];
    end

    assign dirty    = dirty_q;
    assign wr_count = wr_count_q;

endmodule
